// File: rtl/div_pkg.sv
// Shared types and constants for the EX-stage divider issue controller.
package div_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } div_state_t;
endpackage

// File: rtl/div_operand_classify.sv
// Operand decode for the divider issue controller: flags requests that never need the divider.
// DIV_TRIVIAL_BYPASS_EN enables the divide-by-one / zero-dividend shortcut.
module div_operand_classify
    import div_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            is_zero_div,
    output logic            is_trivial
);
    assign is_zero_div = (b == '0);

`ifdef DIV_TRIVIAL_BYPASS_EN
    // Both cases return hi=0, lo=a, so the controller needs no further decode.
    assign is_trivial = (b == XLEN'(1)) || ((a == '0) && (b != '0));
`else
    // Operand a only matters for the bypass.
    assign is_trivial = 1'b0 & (a == '0);
`endif
endmodule

// File: rtl/div_issue_ctrl.sv
// Sequences the multi-cycle divider for EX: stalls the pipe, holds div_start until
// div_ready, writes HI/LO once, and drains a flushed divide. Optional: DIV_TRIVIAL_BYPASS_EN.
module div_issue_ctrl
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_signed,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    input  logic              flush,
    output logic              stall,
    output logic              hilo_we,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo,
    output logic              busy,
    output logic              div_start,
    output logic              div_signed,
    output logic [XLEN-1:0]   div_a,
    output logic [XLEN-1:0]   div_b,
    input  logic [2*XLEN-1:0] div_result,
    input  logic              div_ready
);
    div_state_t state;
    logic       is_zero_div;
    logic       is_trivial;

    div_operand_classify u_classify (
        .a           (req_a),
        .b           (req_b),
        .is_zero_div (is_zero_div),
        .is_trivial  (is_trivial)
    );

    // DONE releases the stall so EX advances exactly once per divide.
    assign stall     = req_valid & ~flush & (state != DONE);
    assign hilo_we   = (state == DONE) & ~flush;
    assign busy      = (state != IDLE);
    assign div_start = (state == RUN) | (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hi         <= '0;
            lo         <= '0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        if (is_zero_div) begin
                            hi    <= req_a;
                            lo    <= ZERO_QUOT;
                            state <= DONE;
                        end else if (is_trivial) begin
                            hi    <= '0;
                            lo    <= req_a;
                            state <= DONE;
                        end else begin
                            div_signed <= req_signed;
                            div_a      <= req_a;
                            div_b      <= req_b;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (div_ready) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            hi    <= div_result[2*XLEN-1:XLEN];
                            lo    <= div_result[XLEN-1:0];
                            state <= DONE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                // The divider cannot be aborted; keep start high until it finishes.
                DRAIN: begin
                    if (div_ready) state <= IDLE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
